// File: rtl/fb_mem_stage.sv
// MEM-stage load/store unit: runs one req/ack data-bus access per memory op, stalls the
// pipeline while it is outstanding, and formats store lanes and load results for MEM/WB.
module fb_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        mem_mem_to_reg,
    input  logic        mem_reg_write,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_rs2_data,
    input  logic [4:0]  mem_register_rd,
    input  logic [2:0]  mem_funct3,

    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_err,

    output logic        mem_stall,
    output logic [31:0] memwb_alu_res,
    output logic [31:0] memwb_load_data,
    output logic [4:0]  memwb_register_rd,
    output logic        memwb_mem_to_reg,
    output logic        memwb_reg_write,
    output logic        exc_addr,
    output logic        exc_bus_err
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] load_q, load_d;

    logic        mem_op;
    logic        illegal;
    logic        legal_op;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] lane;
    logic [31:0] load_fmt;
    logic        timeout_hit;

    assign mem_op = mem_mem_read | mem_mem_write;

    always_comb begin
        illegal = 1'b0;
        if (mem_funct3 == 3'b011 || mem_funct3 == 3'b110 || mem_funct3 == 3'b111) begin
            illegal = 1'b1;
        end
        if (mem_funct3[1:0] == 2'b01 && mem_alu_res[0]) begin
            illegal = 1'b1;
        end
        if (mem_funct3[1:0] == 2'b10 && mem_alu_res[1:0] != 2'b00) begin
            illegal = 1'b1;
        end
        // Unsigned sizes only exist for loads.
        if (mem_mem_write && mem_funct3[2]) begin
            illegal = 1'b1;
        end
    end

    assign legal_op = mem_op & ~illegal;

    always_comb begin
        st_wdata = mem_rs2_data;
        st_be    = 4'b1111;
        case (mem_funct3[1:0])
            2'b00: begin
                st_wdata = {4{mem_rs2_data[7:0]}};
                st_be    = 4'b0001 << mem_alu_res[1:0];
            end
            2'b01: begin
                st_wdata = {2{mem_rs2_data[15:0]}};
                st_be    = 4'b0011 << mem_alu_res[1:0];
            end
            default: begin
                st_wdata = mem_rs2_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    assign lane = dbus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_fmt = dbus_rdata;
        case (f3_q)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'h0, lane[7:0]};
            3'b101:  load_fmt = {16'h0, lane[15:0]};
            default: load_fmt = dbus_rdata;
        endcase
    end

    assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        off_d   = off_q;
        f3_d    = f3_q;
        load_d  = load_q;
        unique case (state_q)
            StIdle: begin
                if (legal_op) begin
                    we_d    = mem_mem_write;
                    addr_d  = {mem_alu_res[31:2], 2'b00};
                    wdata_d = mem_mem_write ? st_wdata : mem_rs2_data;
                    be_d    = mem_mem_write ? st_be : 4'b1111;
                    off_d   = mem_alu_res[1:0];
                    f3_d    = mem_funct3;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 8'd1;
                // An ack in the final allowed cycle takes priority over the timeout.
                if (dbus_ack) begin
                    load_d  = load_fmt;
                    err_d   = dbus_err;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            load_q  <= load_d;
        end
    end

    assign dbus_req    = (state_q == StReq);
    assign dbus_we     = we_q;
    assign dbus_addr   = addr_q;
    assign dbus_wdata  = wdata_q;
    assign dbus_be     = be_q;

    assign mem_stall   = ((state_q == StIdle) && legal_op) || (state_q == StReq);
    assign exc_addr    = (state_q == StIdle) && mem_op && illegal && !rst;
    assign exc_bus_err = (state_q == StDone) && err_q;

    assign memwb_alu_res     = mem_alu_res;
    assign memwb_load_data   = load_q;
    assign memwb_register_rd = mem_register_rd;
    assign memwb_mem_to_reg  = mem_mem_to_reg;
    assign memwb_reg_write   = mem_reg_write & ~exc_addr & ~exc_bus_err;

endmodule

// File: tb/tb_fb_mem_stage.sv
// Directed bench for fb_mem_stage (TIMEOUT_CYCLES = 4): loads, stores, illegal ops,
// timeout, bus error and reset during an access.
module tb_fb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
    logic [31:0] mem_alu_res, mem_rs2_data;
    logic [4:0]  mem_register_rd;
    logic [2:0]  mem_funct3;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        dbus_err;
    logic        mem_stall;
    logic [31:0] memwb_alu_res, memwb_load_data;
    logic [4:0]  memwb_register_rd;
    logic        memwb_mem_to_reg, memwb_reg_write, exc_addr, exc_bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    int          stalls, reqs;
    logic [31:0] o_addr, o_wdata, o_load;
    logic [3:0]  o_be;
    logic        o_we, o_berr, o_rw, o_to;

    fb_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_mem_read      (mem_mem_read),
        .mem_mem_write     (mem_mem_write),
        .mem_mem_to_reg    (mem_mem_to_reg),
        .mem_reg_write     (mem_reg_write),
        .mem_alu_res       (mem_alu_res),
        .mem_rs2_data      (mem_rs2_data),
        .mem_register_rd   (mem_register_rd),
        .mem_funct3        (mem_funct3),
        .dbus_req          (dbus_req),
        .dbus_we           (dbus_we),
        .dbus_addr         (dbus_addr),
        .dbus_wdata        (dbus_wdata),
        .dbus_be           (dbus_be),
        .dbus_ack          (dbus_ack),
        .dbus_rdata        (dbus_rdata),
        .dbus_err          (dbus_err),
        .mem_stall         (mem_stall),
        .memwb_alu_res     (memwb_alu_res),
        .memwb_load_data   (memwb_load_data),
        .memwb_register_rd (memwb_register_rd),
        .memwb_mem_to_reg  (memwb_mem_to_reg),
        .memwb_reg_write   (memwb_reg_write),
        .exc_addr          (exc_addr),
        .exc_bus_err       (exc_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        mem_mem_read    = 1'b0;
        mem_mem_write   = 1'b0;
        mem_mem_to_reg  = 1'b0;
        mem_reg_write   = 1'b0;
        mem_alu_res     = 32'h0;
        mem_rs2_data    = 32'h0;
        mem_register_rd = 5'd0;
        mem_funct3      = 3'b000;
    endtask

    // Present one op and step it to DONE; ack is raised in REQ cycle ack_at (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input int ack_at, input logic [31:0] rdata, input logic err,
                              output int n_stall, output int n_req,
                              output logic [31:0] a, output logic [31:0] wd,
                              output logic [3:0] be, output logic we,
                              output logic [31:0] ld, output logic berr,
                              output logic rw, output logic to);
        n_stall = 0; n_req = 0; a = '0; wd = '0; be = '0; we = 1'b0;
        ld = '0; berr = 1'b0; rw = 1'b0; to = 1'b1;
        mem_mem_read    = rd;
        mem_mem_write   = wr;
        mem_mem_to_reg  = rd;
        mem_reg_write   = 1'b1;
        mem_funct3      = f3;
        mem_alu_res     = addr;
        mem_rs2_data    = rs2;
        mem_register_rd = 5'd7;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #2;
            if (cyc > 0 && !mem_stall && !dbus_req) begin
                ld = memwb_load_data; berr = exc_bus_err; rw = memwb_reg_write; to = 1'b0;
                break;
            end
            if (mem_stall) n_stall++;
            if (dbus_req) begin
                n_req++;
                if (n_req == 1) begin
                    a = dbus_addr; wd = dbus_wdata; be = dbus_be; we = dbus_we;
                end
                if (n_req == ack_at) begin
                    dbus_ack = 1'b1; dbus_rdata = rdata; dbus_err = err;
                end
            end
            next_cycle();
            dbus_ack = 1'b0;
            dbus_err = 1'b0;
        end
        next_cycle();
        set_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_nop();
        dbus_ack = 1'b0; dbus_rdata = 32'h0; dbus_err = 1'b0;
        next_cycle();
        next_cycle();
        #2;
        chk("rst_req",   {31'h0, dbus_req},  32'h0);
        chk("rst_we",    {31'h0, dbus_we},   32'h0);
        chk("rst_addr",  dbus_addr,          32'h0);
        chk("rst_wdata", dbus_wdata,         32'h0);
        chk("rst_be",    {28'h0, dbus_be},   32'h0);
        chk("rst_load",  memwb_load_data,    32'h0);
        chk("rst_exc",   {30'h0, exc_addr, exc_bus_err}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        rst = 1'b0;
        next_cycle();

        // LW 0x100, ack in first REQ cycle
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("lw_done",  {31'h0, o_to},     32'h0);
        chk("lw_addr",  o_addr,            32'h100);
        chk("lw_be",    {28'h0, o_be},     32'hF);
        chk("lw_we",    {31'h0, o_we},     32'h0);
        chk("lw_stall", stalls,            32'd2);
        chk("lw_reqs",  reqs,              32'd1);
        chk("lw_data",  o_load,            32'hDEADBEEF);
        chk("lw_rw",    {31'h0, o_rw},     32'h1);
        next_cycle();

        run_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0011, 0,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("lb_addr", o_addr, 32'h100);
        chk("lb_data", o_load, 32'hFFFFFF80);
        next_cycle();

        run_access(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF0011, 0,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("lbu_data",  o_load, 32'h00000080);
        chk("lbu_stall", stalls, 32'd3);
        next_cycle();

        run_access(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF0011, 0,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("lh_data", o_load, 32'hFFFF80FF);
        next_cycle();

        // SH at 0x202, ack in REQ cycle 4: also the timeout-cycle tie that the ack must win
        run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 4, 32'h0, 0,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("sh_addr",  o_addr,        32'h200);
        chk("sh_wdata", o_wdata,       32'hABCDABCD);
        chk("sh_be",    {28'h0, o_be}, 32'hC);
        chk("sh_we",    {31'h0, o_we}, 32'h1);
        chk("sh_stall", stalls,        32'd5);
        chk("sh_berr",  {31'h0, o_berr}, 32'h0);
        next_cycle();

        run_access(0, 1, 3'b000, 32'h201, 32'h000000A5, 1, 32'h0, 0,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("sb_wdata", o_wdata,       32'hA5A5A5A5);
        chk("sb_be",    {28'h0, o_be}, 32'h2);
        next_cycle();

        // Read and write both set: treated as SW
        run_access(1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 1, 32'h0, 0,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("rw_we",    {31'h0, o_we}, 32'h1);
        chk("rw_wdata", o_wdata,       32'hCAFEF00D);
        chk("rw_be",    {28'h0, o_be}, 32'hF);
        next_cycle();

        // Misaligned LW
        mem_mem_read = 1'b1; mem_mem_to_reg = 1'b1; mem_reg_write = 1'b1;
        mem_funct3 = 3'b010; mem_alu_res = 32'h101; mem_register_rd = 5'd9;
        #2;
        chk("mis_exc",   {31'h0, exc_addr},        32'h1);
        chk("mis_stall", {31'h0, mem_stall},       32'h0);
        chk("mis_rw",    {31'h0, memwb_reg_write}, 32'h0);
        chk("mis_alu",   memwb_alu_res,            32'h101);
        chk("mis_rd",    {27'h0, memwb_register_rd}, 32'd9);
        next_cycle();
        set_nop();
        #2;
        chk("mis_noreq", {31'h0, dbus_req}, 32'h0);
        chk("mis_pulse", {31'h0, exc_addr}, 32'h0);
        next_cycle();

        // Store with unsigned size and load with reserved funct3
        mem_mem_write = 1'b1; mem_funct3 = 3'b100; mem_alu_res = 32'h200;
        #2;
        chk("sbu_exc", {31'h0, exc_addr}, 32'h1);
        next_cycle();
        set_nop();
        mem_mem_read = 1'b1; mem_funct3 = 3'b011; mem_alu_res = 32'h208;
        #2;
        chk("f3_011_exc", {31'h0, exc_addr}, 32'h1);
        next_cycle();
        set_nop();
        #2;
        chk("ill_noreq", {31'h0, dbus_req}, 32'h0);
        next_cycle();

        // No ack: timeout after 4 REQ cycles
        run_access(1, 0, 3'b010, 32'h110, 32'h0, 0, 32'h0, 0,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("to_done",  {31'h0, o_to},   32'h0);
        chk("to_reqs",  reqs,            32'd4);
        chk("to_stall", stalls,          32'd5);
        chk("to_berr",  {31'h0, o_berr}, 32'h1);
        chk("to_rw",    {31'h0, o_rw},   32'h0);
        #2;
        chk("to_pulse", {31'h0, exc_bus_err}, 32'h0);
        next_cycle();

        run_access(1, 0, 3'b010, 32'h120, 32'h0, 2, 32'h11111111, 1,
                   stalls, reqs, o_addr, o_wdata, o_be, o_we, o_load, o_berr, o_rw, o_to);
        chk("err_berr", {31'h0, o_berr}, 32'h1);
        chk("err_rw",   {31'h0, o_rw},   32'h0);
        next_cycle();

        // Reset in REQ cycle 2, then a late ack
        mem_mem_read = 1'b1; mem_mem_to_reg = 1'b1; mem_reg_write = 1'b1;
        mem_funct3 = 3'b010; mem_alu_res = 32'h300;
        next_cycle();
        next_cycle();
        #1;
        chk("rr_req2", {31'h0, dbus_req}, 32'h1);
        rst = 1'b1;
        set_nop();
        next_cycle();
        #1;
        chk("rr_req",   {31'h0, dbus_req},  32'h0);
        chk("rr_stall", {31'h0, mem_stall}, 32'h0);
        rst = 1'b0;
        dbus_ack = 1'b1; dbus_rdata = 32'h55555555;
        next_cycle();
        dbus_ack = 1'b0;
        #1;
        chk("rr_load", memwb_load_data,         32'h0);
        chk("rr_idle", {31'h0, dbus_req},       32'h0);
        chk("rr_berr", {31'h0, exc_bus_err},    32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_mem_stage.md
# fb_mem_stage

MEM-stage access unit of the Firebird 5-stage RV32I pipeline. It sits directly downstream of the EX/MEM register and consumes its control, ALU-result, store-data and rd fields. It runs load/store accesses on a req/ack data bus with variable latency, and stalls the pipeline while an access is outstanding. It formats store data and byte enables, aligns and extends load data, and drives the MEM/WB register inputs.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of cycles in REQ without `dbus_ack` before a bus error is forced. Range 1..255.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_mem_read` in 1: load op, from EX/MEM.
- `mem_mem_write` in 1: store op, from EX/MEM.
- `mem_mem_to_reg` in 1: writeback selects load data, from EX/MEM.
- `mem_reg_write` in 1: rd write enable, from EX/MEM.
- `mem_alu_res` in 32: effective address, or ALU result for non-memory ops.
- `mem_rs2_data` in 32: store data.
- `mem_register_rd` in 5: destination register.
- `mem_funct3` in 3: access size/sign. This is a new EX/MEM field.
- `dbus_req` out 1: access request.
- `dbus_we` out 1: 1 = write.
- `dbus_addr` out 32: word address, bits [1:0] = 0.
- `dbus_wdata` out 32: lane-replicated store data.
- `dbus_be` out 4: byte enables.
- `dbus_ack` in 1: access complete.
- `dbus_rdata` in 32: read data, valid with ack.
- `dbus_err` in 1: bus error, sampled only with ack.
- `mem_stall` out 1: freezes EX/MEM (we=0) and all upstream stages.
- `memwb_alu_res` out 32: pass-through of `mem_alu_res`.
- `memwb_load_data` out 32: extended load result.
- `memwb_register_rd` out 5: pass-through of `mem_register_rd`.
- `memwb_mem_to_reg` out 1: pass-through of `mem_mem_to_reg`.
- `memwb_reg_write` out 1: `mem_reg_write` gated by exceptions.
- `exc_addr` out 1: misaligned or unsupported-size access, 1-cycle pulse.
- `exc_bus_err` out 1: bus error or timeout, 1-cycle pulse.

## Operation
- FSM states:
  - IDLE:
    - Non-memory op: stay in IDLE; `mem_stall` = 0.
    - Legal memory op: latch `dbus_we`, `dbus_addr`, `dbus_wdata` and `dbus_be`; go to REQ.
    - Illegal memory op: pulse `exc_addr`, issue no request, stay in IDLE.
  - REQ:
    - `dbus_req` = 1. Counter increments each cycle.
    - On `dbus_ack`: capture the formatted load data; record `dbus_err`; go to DONE.
    - When the counter reaches `TIMEOUT_CYCLES`: set the error flag; go to DONE.
  - DONE: lasts exactly 1 cycle; returns to IDLE.
- `mem_stall` = 1 in IDLE while a legal memory op is present, and in REQ. `mem_stall` = 0 in DONE, so EX/MEM advances at the end of DONE.
- Illegal conditions:
  - funct3 011, 110 or 111.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
  - funct3 1xx on a store.
- Stores:
  - SB (000): wdata = {4{rs2[7:0]}}, be = 0001 << addr[1:0].
  - SH (001): wdata = {2{rs2[15:0]}}, be = 0011 << addr[1:0].
  - SW (010): wdata = rs2, be = 1111.
- Loads:
  - Select the byte/half lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - `dbus_be` = 1111 for all loads.
- If read and write are both asserted, the op is a store and the read is ignored.
- `dbus_*` outputs are registered and stay stable while `dbus_req` = 1.
- `exc_bus_err` pulses in DONE when the error flag is set.
- `memwb_reg_write` = 0 whenever `exc_addr` or `exc_bus_err` is high in the current cycle.
- `memwb_load_data` holds the last captured value until the next ack.

## Timing
- Reset values:
  - state = IDLE.
  - `dbus_req`, `dbus_we` = 0.
  - `dbus_addr`, `dbus_wdata`, `memwb_load_data` = 0.
  - `dbus_be` = 0.
  - counter = 0, error flag = 0.
  - `exc_*` = 0.
- Pass-through `memwb_*` fields are combinational from the inputs.
- Reset mid-access drops `dbus_req` at the next edge. A late ack in IDLE is ignored.
- Access latency:
  - Op presented in cycle 0; `dbus_req` rises in cycle 1.
  - Ack sampled in cycle k ≥ 1; DONE in cycle k+1.
  - Minimum cost is 3 cycles, 2 of them stalled.
- Ack in the first REQ cycle is legal.
- `dbus_req` drops in DONE, so back-to-back accesses have at least 1 idle bus cycle.
- Timeout:
  - Counter is cleared on entry to REQ.
  - Error is forced at the edge where counter = `TIMEOUT_CYCLES` − 1 and no ack is present.
  - Ack in that same cycle wins over the timeout.
- `exc_addr` is a combinational pulse in the IDLE cycle and causes no stall.

## Test plan
- LW at 0x100 with ack in REQ cycle 1, rdata 0xDEADBEEF → `dbus_addr` = 0x100, be = 1111; `mem_stall` high for 2 cycles; DONE shows `memwb_load_data` = 0xDEADBEEF.
- LB at 0x103 / LBU at 0x103, rdata 0x80FF0011 → `memwb_load_data` = 0xFFFFFF80 / 0x00000080.
- SH rs2 = 0x1234ABCD at 0x202 → wdata = 0xABCDABCD, be = 1100, we = 1; ack after 4 wait cycles → stall for 5 cycles total.
- LW at 0x101 → `exc_addr` pulse, `dbus_req` never rises, `memwb_reg_write` = 0, no stall.
- `TIMEOUT_CYCLES` = 4, no ack → `dbus_req` high for 4 cycles, `exc_bus_err` in DONE, reg_write gated. Also: ack with `dbus_err` = 1 → `exc_bus_err` in DONE.
- `rst` asserted in REQ cycle 2 → next cycle `dbus_req` = 0 and `mem_stall` = 0; an ack arriving afterwards is ignored.
